// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: latched transaction, arbiter FSM state, chip decode.
package hyperbus_pkg;

  localparam int unsigned HyperAddrWidth = 32;
  localparam int unsigned HyperLenWidth  = 16;

  typedef struct packed {
    logic                      write;
    logic [HyperAddrWidth-1:0] addr;
    logic [HyperLenWidth-1:0]  len;
  } hyper_trx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_GAP
  } arb_state_e;

  // Chip index of a word address: everything above the in-chip word bits.
  function automatic logic [63:0] chip_index(input logic [63:0] word_addr,
                                             input int unsigned log2_words);
    return word_addr >> log2_words;
  endfunction

endpackage

// File: rtl/hyperbus_trx_arbiter_if.sv
// Requester and PHY-channel signals of the transaction arbiter.
// master: front-ends plus PHY (environment); slave: the arbiter itself.
interface hyperbus_trx_arbiter_if #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned NumChips      = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned ChipWordsLog2 = 22
);
  logic [NumReq-1:0]                req_valid_i;
  logic [NumReq-1:0]                req_ready_o;
  logic [NumReq-1:0]                req_write_i;
  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i;
  logic [NumReq-1:0][LenWidth-1:0]  req_len_i;
  logic [NumReq-1:0]                req_done_o;
  logic                             req_err_o;
  logic                             phy_valid_o;
  logic                             phy_ready_i;
  logic                             phy_write_o;
  logic [ChipWordsLog2-1:0]         phy_addr_o;
  logic [LenWidth-1:0]              phy_len_o;
  logic [NumChips-1:0]              phy_cs_o;
  logic                             phy_done_i;
  logic                             busy_o;

  modport master (
    output req_valid_i, req_write_i, req_addr_i, req_len_i, phy_ready_i, phy_done_i,
    input  req_ready_o, req_done_o, req_err_o, phy_valid_o, phy_write_o,
           phy_addr_o, phy_len_o, phy_cs_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_write_i, req_addr_i, req_len_i, phy_ready_i, phy_done_i,
    output req_ready_o, req_done_o, req_err_o, phy_valid_o, phy_write_o,
           phy_addr_o, phy_len_o, phy_cs_o, busy_o
  );
endinterface

// File: rtl/hyperbus_rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr.
module hyperbus_rr_pick #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = 1
) (
  input  logic [NumReq-1:0] valid,
  input  logic [IdxW-1:0]   ptr,
  output logic [NumReq-1:0] grant,
  output logic [IdxW-1:0]   idx
);

  logic        found;
  int unsigned pos;

  // Scan NumReq positions starting at ptr, wrapping; first valid wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      pos = (32'(ptr) + i) % NumReq;
      if (!found && valid[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/hyperbus_trx_arbiter.sv
// Shares the HyperBus PHY transaction channel between requesters:
// round-robin per request, chip-select decode, MaxBurst/chip-boundary chunking.
module hyperbus_trx_arbiter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned NumChips      = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned LenWidth      = 16,
  parameter int unsigned MaxBurst      = 256,
  parameter int unsigned ChipWordsLog2 = 22
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  hyperbus_trx_arbiter_if.slave bus
);

  localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  // Wide enough for both the remaining length and the full-chip room term.
  localparam int unsigned CalcW = ((LenWidth > ChipWordsLog2) ? LenWidth : ChipWordsLog2) + 1;

  arb_state_e        state_q, state_d;
  hyper_trx_t        trx_q, trx_d;      // addr = current address, len = remaining words
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [NumReq-1:0] done_q, done_d;
  logic              err_q, err_d;

  logic [NumReq-1:0] pick_gnt;
  logic [IdxW-1:0]   pick_idx;
  logic [NumReq-1:0] ready;
  logic [CalcW-1:0]  chip_room, chunk;
  logic [AddrWidth-1:0]      next_addr;
  logic [HyperLenWidth-1:0]  next_rem;
  logic [63:0]       cur_chip;
  logic              issue;

  hyperbus_rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .valid (bus.req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (pick_gnt),
    .idx   (pick_idx)
  );

  assign ready     = (state_q == ST_IDLE && !rst_i) ? pick_gnt : '0;
  assign chip_room = (CalcW'(1) << ChipWordsLog2) - CalcW'(trx_q.addr[ChipWordsLog2-1:0]);
  assign next_addr = AddrWidth'(trx_q.addr) + AddrWidth'(chunk);
  assign next_rem  = trx_q.len - HyperLenWidth'(chunk);
  assign cur_chip  = chip_index(64'(trx_q.addr), ChipWordsLog2);
  assign issue     = (state_q == ST_ISSUE);

  // Chunk = min(remaining, MaxBurst, words left in the current chip).
  always_comb begin
    chunk = CalcW'(trx_q.len);
    if (chunk > CalcW'(MaxBurst)) chunk = CalcW'(MaxBurst);
    if (chunk > chip_room)        chunk = chip_room;
  end

  // Next-state logic: arbitration, validity check, chunk bookkeeping.
  always_comb begin
    state_d   = state_q;
    trx_d     = trx_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_idx_d = gnt_idx_q;
    done_d    = '0;
    err_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|ready) begin
          gnt_idx_d   = pick_idx;
          rr_ptr_d    = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
          trx_d.write = bus.req_write_i[pick_idx];
          trx_d.addr  = HyperAddrWidth'(bus.req_addr_i[pick_idx]);
          trx_d.len   = HyperLenWidth'(bus.req_len_i[pick_idx]);
          if (bus.req_len_i[pick_idx] == '0 ||
              chip_index(64'(bus.req_addr_i[pick_idx]), ChipWordsLog2) >= 64'(NumChips)) begin
            done_d[pick_idx] = 1'b1;
            err_d            = 1'b1;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.phy_ready_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.phy_done_i) begin
          trx_d.len  = next_rem;
          trx_d.addr = HyperAddrWidth'(next_addr);
          if (next_rem == '0) begin
            state_d           = ST_IDLE;
            done_d[gnt_idx_q] = 1'b1;
          end else if (chip_index(64'(next_addr), ChipWordsLog2) >= 64'(NumChips)) begin
            // Ran off the last chip: drop the rest and report an error.
            state_d           = ST_IDLE;
            done_d[gnt_idx_q] = 1'b1;
            err_d             = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP:  state_d = ST_ISSUE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered completion pulses, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      trx_q     <= '0;
      rr_ptr_q  <= '0;
      gnt_idx_q <= '0;
      done_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      trx_q     <= trx_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_idx_q <= gnt_idx_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.req_ready_o = ready;
  assign bus.req_done_o  = done_q;
  assign bus.req_err_o   = err_q;
  assign bus.phy_valid_o = issue;
  assign bus.phy_write_o = issue & trx_q.write;
  assign bus.phy_addr_o  = issue ? trx_q.addr[ChipWordsLog2-1:0] : '0;
  assign bus.phy_len_o   = issue ? LenWidth'(chunk) : '0;
  assign bus.phy_cs_o    = issue ? (NumChips'(1) << cur_chip) : '0;
  assign bus.busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hyperbus_trx_arbiter.sv
// Self-checking bench for hyperbus_trx_arbiter against a chunk-list model.
module tb_hyperbus_trx_arbiter;

  localparam int unsigned N_REQ     = 2;
  localparam int unsigned N_CHIPS   = 2;
  localparam int unsigned MAX_BURST = 256;
  localparam int unsigned CHIP_LOG2 = 22;
  localparam longint unsigned CHIP_WORDS = 64'd1 << CHIP_LOG2;

  typedef struct {
    int unsigned cs;
    int unsigned addr;
    int unsigned len;
  } chunk_t;

  logic clk   = 1'b0;
  logic rst_i = 1'b1;
  int errors  = 0;
  int checks  = 0;

  chunk_t exp_q[$];
  bit     exp_err;
  bit     exp_rej;

  hyperbus_trx_arbiter_if #(
    .NumReq(N_REQ), .NumChips(N_CHIPS), .AddrWidth(32), .LenWidth(16), .ChipWordsLog2(CHIP_LOG2)
  ) bus ();

  hyperbus_trx_arbiter #(
    .NumReq(N_REQ), .NumChips(N_CHIPS), .AddrWidth(32), .LenWidth(16),
    .MaxBurst(MAX_BURST), .ChipWordsLog2(CHIP_LOG2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Expected PHY chunks of one request, walked word-range by word-range.
  task automatic build_model(input longint unsigned a, input int unsigned len);
    longint unsigned cur = a;
    int unsigned rem = len;
    longint unsigned chip, room;
    int unsigned c;
    exp_q.delete();
    exp_err = 0;
    exp_rej = 0;
    if (len == 0 || (a / CHIP_WORDS) >= N_CHIPS) begin
      exp_rej = 1;
      exp_err = 1;
      return;
    end
    while (rem > 0) begin
      chip = cur / CHIP_WORDS;
      room = CHIP_WORDS - (cur % CHIP_WORDS);
      if (chip >= N_CHIPS) begin
        exp_err = 1;
        break;
      end
      c = rem;
      if (c > MAX_BURST) c = MAX_BURST;
      if (c > room) c = int'(room);
      exp_q.push_back('{cs: 32'd1 << chip, addr: int'(cur % CHIP_WORDS), len: c});
      cur += c;
      rem -= c;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    #1;
  endtask

  // Called at the accept cycle N; plays the PHY from N+1 until the done pulse.
  task automatic serve_chunks(input int idx, input logic wr, input bit drop);
    logic [1:0] oh;
    int dly;
    oh = 2'b01 << idx;
    @(negedge clk);
    if (drop) bus.req_valid_i[idx] = 1'b0;
    #1;
    if (exp_rej) begin
      checks++;
      if (bus.req_done_o !== oh || bus.req_err_o !== 1'b1 || bus.phy_valid_o !== 1'b0)
        $display("FAIL reject: done=%b err=%b phy_valid=%b, expected done=%b err=1 phy_valid=0",
                 bus.req_done_o, bus.req_err_o, bus.phy_valid_o, oh);
      if (bus.req_done_o !== oh || bus.req_err_o !== 1'b1 || bus.phy_valid_o !== 1'b0) errors++;
      return;
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k > 0) begin
        checks++;
        if (bus.phy_valid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.req_done_o !== '0) begin
          errors++;
          $display("FAIL gap: phy_valid=%b busy=%b done=%b, expected 0 1 00",
                   bus.phy_valid_o, bus.busy_o, bus.req_done_o);
        end
        @(negedge clk); #1;
      end
      dly = $urandom_range(0, 2);
      for (int d = 0; d <= dly; d++) begin
        checks++;
        if (bus.phy_valid_o !== 1'b1 || bus.phy_cs_o !== exp_q[k].cs ||
            bus.phy_addr_o !== exp_q[k].addr || bus.phy_len_o !== exp_q[k].len ||
            bus.phy_write_o !== wr) begin
          errors++;
          $display("FAIL chunk%0d: valid=%b cs=%b addr=%h len=%0d wr=%b, expected 1 cs=%0d addr=%h len=%0d wr=%b",
                   k, bus.phy_valid_o, bus.phy_cs_o, bus.phy_addr_o, bus.phy_len_o, bus.phy_write_o,
                   exp_q[k].cs, exp_q[k].addr, exp_q[k].len, wr);
        end
        if (d == dly) bus.phy_ready_i = 1'b1;
        bus.phy_done_i = 1'($urandom_range(0, 1));  // must be ignored while issuing
        @(negedge clk);
        bus.phy_ready_i = 1'b0;
        bus.phy_done_i  = 1'b0;
        #1;
      end
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        checks++;
        if (bus.phy_valid_o !== 1'b0 || bus.req_done_o !== '0) begin
          errors++;
          $display("FAIL wait_done: phy_valid=%b done=%b, expected 0 00", bus.phy_valid_o, bus.req_done_o);
        end
        @(negedge clk); #1;
      end
      bus.phy_done_i = 1'b1;
      @(negedge clk);
      bus.phy_done_i = 1'b0;
      #1;
    end
    checks++;
    if (bus.req_done_o !== oh || bus.req_err_o !== exp_err || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL complete: done=%b err=%b busy=%b, expected done=%b err=%b busy=0",
               bus.req_done_o, bus.req_err_o, bus.busy_o, oh, exp_err);
    end
  endtask

  task automatic do_request(input int idx, input logic wr, input logic [31:0] addr, input logic [15:0] len);
    logic [1:0] oh;
    int n = 0;
    oh = 2'b01 << idx;
    build_model(addr, len);
    @(negedge clk);
    bus.req_valid_i[idx] = 1'b1;
    bus.req_write_i[idx] = wr;
    bus.req_addr_i[idx]  = addr;
    bus.req_len_i[idx]   = len;
    #1;
    while (bus.req_ready_o[idx] !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (bus.req_ready_o !== oh) begin
      errors++;
      $display("FAIL accept: ready=%b, expected %b", bus.req_ready_o, oh);
      bus.req_valid_i[idx] = 1'b0;
      return;
    end
    serve_chunks(idx, wr, 1'b1);
    @(negedge clk); #1;
    checks++;
    if (bus.req_done_o !== '0 || bus.req_err_o !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width: done=%b err=%b one cycle later, expected 00 0", bus.req_done_o, bus.req_err_o);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if (bus.req_ready_o !== '0 || bus.req_done_o !== '0 || bus.req_err_o !== 1'b0 ||
        bus.phy_valid_o !== 1'b0 || bus.phy_write_o !== 1'b0 || bus.phy_addr_o !== '0 ||
        bus.phy_len_o !== '0 || bus.phy_cs_o !== '0 || bus.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b done=%b err=%b valid=%b wr=%b addr=%h len=%0d cs=%b busy=%b, expected all 0",
               name, bus.req_ready_o, bus.req_done_o, bus.req_err_o, bus.phy_valid_o, bus.phy_write_o,
               bus.phy_addr_o, bus.phy_len_o, bus.phy_cs_o, bus.busy_o);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_all_zero("reset");
  endtask

  task automatic test_single_write();
    do_request(0, 1'b1, 32'h100, 16'd4);
  endtask

  task automatic test_long_burst();
    do_request(1, 1'b0, 32'h0, 16'd600);
  endtask

  task automatic test_chip_crossing();
    do_request(0, 1'b1, 32'h3F_FFF0, 16'd32);
  endtask

  task automatic test_fairness();
    int ptr = 0;
    int win, n;
    logic [1:0] oh;
    bus.req_valid_i = 2'b11;
    for (int i = 0; i < 2; i++) begin
      bus.req_write_i[i] = 1'(i);
      bus.req_addr_i[i]  = 32'h10 * (i + 1);
      bus.req_len_i[i]   = 16'd4;
    end
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (bus.req_ready_o === '0 && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      win = ptr;  // both always valid: the pointer position wins
      oh = 2'b01 << win;
      checks++;
      if (bus.req_ready_o !== oh) begin
        errors++;
        $display("FAIL fairness%0d: ready=%b, expected %b", r, bus.req_ready_o, oh);
      end
      ptr = (win + 1) % N_REQ;
      build_model(32'h10 * (win + 1), 4);
      serve_chunks(win, 1'(win), 1'b0);
    end
    bus.req_valid_i = '0;
    @(negedge clk); #1;
  endtask

  task automatic test_rejection();
    do_request(0, 1'b1, 32'h80_0000, 16'd8);
    do_request(1, 1'b0, 32'h0, 16'd0);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    @(negedge clk);
    bus.req_valid_i[0] = 1'b1;
    bus.req_write_i[0] = 1'b0;
    bus.req_addr_i[0]  = 32'h0;
    bus.req_len_i[0]   = 16'd600;
    #1;
    while (bus.req_ready_o[0] !== 1'b1 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(negedge clk);
    bus.req_valid_i[0] = 1'b0;
    #1;
    checks++;
    if (bus.phy_valid_o !== 1'b1 || bus.phy_len_o !== 16'd256) begin
      errors++;
      $display("FAIL reset_mid_issue: valid=%b len=%0d, expected 1 256", bus.phy_valid_o, bus.phy_len_o);
    end
    bus.phy_ready_i = 1'b1;
    @(negedge clk);
    bus.phy_ready_i = 1'b0;
    rst_i = 1'b1;  // now in WAIT_DONE
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk); #1;
    check_all_zero("reset_mid_no_done");
    bus.req_valid_i = 2'b11;
    bus.req_addr_i[0] = 32'h20;
    bus.req_len_i[0]  = 16'd4;
    #1;
    checks++;
    if (bus.req_ready_o !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid_ptr: ready=%b, expected 01", bus.req_ready_o);
    end
    bus.req_valid_i[1] = 1'b0;
    #1;
    build_model(32'h20, 4);
    serve_chunks(0, 1'b0, 1'b1);
    @(negedge clk); #1;
  endtask

  task automatic test_random();
    int idx, sel;
    logic wr;
    logic [31:0] addr;
    logic [15:0] len;
    for (int t = 0; t < 25; t++) begin
      idx = $urandom_range(0, 1);
      wr  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      len = 16'($urandom_range(1, 700));
      case (sel)
        0:       addr = 32'h80_0000 + $urandom_range(0, 1000);
        1:       begin addr = $urandom_range(0, 32'h7F_FFFF); len = 16'd0; end
        2, 3:    addr = 32'h3F_FF00 + $urandom_range(0, 255);
        4:       addr = 32'h7F_FF00 + $urandom_range(0, 255);
        default: addr = $urandom_range(0, 32'h7F_FFFF);
      endcase
      do_request(idx, wr, addr, len);
    end
  endtask

  initial begin
    bus.req_valid_i = '0;
    bus.req_write_i = '0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    bus.phy_ready_i = 1'b0;
    bus.phy_done_i  = 1'b0;
    test_reset();
    test_single_write();
    test_long_burst();
    test_chip_crossing();
    test_fairness();
    test_rejection();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
